// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW core front end.
// Bundle geometry, the HALT encoding and the fetch FSM states.
package vliw_pkg;

   localparam int SLOT_W    = 32;
   localparam int NUM_SLOTS = 6;
   localparam int BUNDLE_W  = SLOT_W * NUM_SLOTS;

   localparam logic [BUNDLE_W-1:0] HALT_BUNDLE = '0;

   typedef enum logic [1:0] {
      S_START,
      S_RUN,
      S_HALT
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of {pc, bundle} between imem return and decode.
// Head outputs read as zero while the FIFO is empty.
module fetch_skid_fifo
   import vliw_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                push,
   input  logic [PC_W-1:0]     pushPc,
   input  logic [BUNDLE_W-1:0] pushData,
   input  logic                pop,
   output logic [1:0]          count,
   output logic                headValid,
   output logic [PC_W-1:0]     headPc,
   output logic [BUNDLE_W-1:0] headData
);

   logic [PC_W-1:0]     pcMem   [2];
   logic [BUNDLE_W-1:0] dataMem [2];
   logic                wrPtr;
   logic                rdPtr;
   logic                doPush;
   logic                doPop;

   assign doPop     = pop && (count != 2'd0);
   assign doPush    = push && ((count != 2'd2) || doPop);
   assign headValid = (count != 2'd0);
   assign headPc    = headValid ? pcMem[rdPtr] : '0;
   assign headData  = headValid ? dataMem[rdPtr] : '0;

   // Pointer and occupancy bookkeeping; flush empties in one edge.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wrPtr <= 1'b0;
         rdPtr <= 1'b0;
         count <= 2'd0;
      end else begin
         if (doPush) wrPtr <= ~wrPtr;
         if (doPop)  rdPtr <= ~rdPtr;
         count <= count + 2'(doPush) - 2'(doPop);
      end
   end

   // Storage needs no reset; only occupied entries are ever visible.
   always_ff @(posedge clk) begin
      if (doPush && !flush && !rst) begin
         pcMem[wrPtr]   <= pushPc;
         dataMem[wrPtr] <= pushData;
      end
   end

endmodule

// File: rtl/vliw_fetch_stage.sv
// Instruction fetch for the 6-slot VLIW core.
// Issues imem reads, tracks one in-flight return, buffers bundles for decode.
module vliw_fetch_stage
   import vliw_pkg::*;
#(
   parameter int IMEM_AW = 8,
   parameter int PC_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_en,
   output logic [IMEM_AW-1:0]  imem_addr,
   input  logic [BUNDLE_W-1:0] imem_rdata,
   input  logic                redirect_valid,
   input  logic [PC_W-1:0]     redirect_pc,
   output logic                bundle_valid,
   input  logic                bundle_ready,
   output logic [BUNDLE_W-1:0] bundle_data,
   output logic [PC_W-1:0]     bundle_pc,
   output logic                halted
);

   fetch_state_t    state;
   logic [PC_W-1:0] fetchPc;
   logic [PC_W-1:0] inflightPc;
   logic [PC_W-1:0] issuePc;
   logic            inflight;
   logic            pop;
   logic            push;
   logic            haltSeen;
   logic            canIssue;
   logic [1:0]      count;
   logic [2:0]      occupancy;

   // A return is kept only while running and not being redirected;
   // returns landing after HALT or behind a redirect are stale.
   assign pop       = bundle_valid && bundle_ready;
   assign push      = inflight && (state == S_RUN) && !redirect_valid;
   assign haltSeen  = push && (imem_rdata == HALT_BUNDLE);
   assign occupancy = 3'(count) + 3'(inflight) - 3'(pop);
   assign canIssue  = (state == S_RUN) && (occupancy < 3'd2);
   assign imem_en   = !rst && (redirect_valid || canIssue);
   assign issuePc   = redirect_valid ? redirect_pc : fetchPc;
   assign imem_addr = issuePc[IMEM_AW-1:0];
   assign halted    = (state == S_HALT);

   // Fetch FSM, fetch PC and the single in-flight request tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_START;
         fetchPc    <= '0;
         inflight   <= 1'b0;
         inflightPc <= '0;
      end else begin
         inflight <= imem_en;
         if (imem_en) begin
            inflightPc <= issuePc;
            fetchPc    <= issuePc + 1'b1;
         end
         unique case (1'b1)
            redirect_valid:
               state <= S_RUN;
            !redirect_valid && (state == S_START):
               state <= S_RUN;
            haltSeen:
               state <= S_HALT;
            default:
               state <= state;
         endcase
      end
   end

   fetch_skid_fifo #(
      .PC_W(PC_W)
   ) uFifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect_valid),
      .push     (push),
      .pushPc   (inflightPc),
      .pushData (imem_rdata),
      .pop      (pop),
      .count    (count),
      .headValid(bundle_valid),
      .headPc   (bundle_pc),
      .headData (bundle_data)
   );

endmodule
